// File: rtl/cpu_pkg.sv
// Shared CPU constants: default word/address widths, the NOP encoding and
// opcode field widths, plus the fetch-control decision type used by instr_mem.
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 8;
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;

    // Instruction field widths for a 32-bit R/I-type encoding.
    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_ACCEPT,
        FETCH_HOLD
    } fetch_op_e;

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: synchronous write, registered read, and an optional
// even-parity column enabled by macro INSTR_MEM_PARITY_EN.
module instr_mem_array
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DEPTH  = 256,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(CPU_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_par_err_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the storage array has no reset, so its contents survive rst and it
    // still maps onto a RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking <= so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= NOP_INSTR;
        end else if (re_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

`ifdef INSTR_MEM_PARITY_EN
    logic par_q [DEPTH];
    logic rd_par_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            par_q[wr_addr_i] <= ^wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_par_q <= 1'b0;
        end else if (re_i) begin
            rd_par_q <= par_q[rd_addr_i];
        end
    end

    // Even parity: word plus stored bit must have an even number of ones.
    assign rd_par_err_o = ^{rd_data_q, rd_par_q};
`else
    assign rd_par_err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with fetch handshake, downstream stall hold and
// out-of-range / parity flags; parity is enabled by macro INSTR_MEM_PARITY_EN.
module instr_mem
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DEPTH  = 256,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(CPU_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              stall,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              addr_err,
    output logic              par_err
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              hold, accept, fetch_in_range, load_in_range;
    logic [DATA_W-1:0] rd_data;
    logic              rd_par_err;
    fetch_op_e         op;

    assign hold           = stall && valid_q;
    assign fetch_ready    = !load_en && !hold;
    assign accept         = fetch_req && fetch_ready;
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_LIM;
    assign load_in_range  = {1'b0, load_addr} < DEPTH_LIM;

    // NOTE: defaults are assigned first so every path drives every signal and
    // no latch is inferred.
    always_comb begin
        op      = FETCH_IDLE;
        valid_d = 1'b0;
        addr_d  = addr_q;
        err_d   = err_q;
        if (hold) begin
            op = FETCH_HOLD;
        end else if (accept) begin
            op = FETCH_ACCEPT;
        end
        case (op)
            FETCH_HOLD: valid_d = 1'b1;
            FETCH_ACCEPT: begin
                valid_d = 1'b1;
                addr_d  = fetch_addr;
                err_d   = !fetch_in_range;
            end
            default: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Loads seen on an edge while rst is high are dropped; out-of-range reads
    // leave the read register alone and are masked to NOP below.
    instr_mem_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .we_i         (load_en && load_in_range && !rst),
        .wr_addr_i    (load_addr),
        .wr_data_i    (load_data),
        .re_i         (accept && fetch_in_range),
        .rd_addr_i    (fetch_addr),
        .rd_data_o    (rd_data),
        .rd_par_err_o (rd_par_err)
    );

    assign instr_valid = valid_q;
    assign instr_addr  = addr_q;
    assign instr_out   = err_q ? NOP_INSTR : rd_data;
    assign addr_err    = valid_q && err_q;
    assign par_err     = valid_q && !err_q && rd_par_err;

endmodule
